// File: rtl/output_drain_fifo_pkg.sv
// Shared types for the output drain FIFO: controller states and the result entry layout.
package output_drain_fifo_pkg;

  localparam int ODF_DATA_WIDTH  = 32;
  localparam int ODF_COORD_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } odf_state_e;

  // Field order is fixed: data in the MSBs, then x, y, ch.
  typedef struct packed {
    logic [ODF_DATA_WIDTH-1:0]  data;
    logic [ODF_COORD_WIDTH-1:0] x;
    logic [ODF_COORD_WIDTH-1:0] y;
    logic [ODF_COORD_WIDTH-1:0] ch;
  } odf_entry_t;

  // Width of one packed entry for a given data/coordinate width.
  function automatic int entry_width(input int dw, input int cw);
    return dw + 3 * cw;
  endfunction

endpackage

// File: rtl/output_drain_fifo_if.sv
// Result-in / result-out handshake bundle between producer, drain FIFO and host.
interface output_drain_fifo_if
  import output_drain_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = ODF_DATA_WIDTH,
  parameter int COORD_WIDTH = ODF_COORD_WIDTH
);

  logic                   in_valid;
  logic [DATA_WIDTH-1:0]  in_data;
  logic [COORD_WIDTH-1:0] in_x;
  logic [COORD_WIDTH-1:0] in_y;
  logic [COORD_WIDTH-1:0] in_ch;

  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_WIDTH-1:0]  out_data;
  logic [COORD_WIDTH-1:0] out_x;
  logic [COORD_WIDTH-1:0] out_y;
  logic [COORD_WIDTH-1:0] out_ch;

  // Producer and host side.
  modport master (
    output in_valid, in_data, in_x, in_y, in_ch, out_ready,
    input  out_valid, out_data, out_x, out_y, out_ch
  );

  // FIFO side.
  modport slave (
    input  in_valid, in_data, in_x, in_y, in_ch, out_ready,
    output out_valid, out_data, out_x, out_y, out_ch
  );

endinterface

// File: rtl/output_drain_fifo_sync_fifo.sv
// Storage array, wrap-around pointers and occupancy counter. The caller decides
// when a write or read is legal; this block only carries them out.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     arst_n_in,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Entry storage; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Occupancy: a simultaneous write and read leaves it unchanged.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      count <= '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Head is read straight from the registered array: no path from wr_data.
  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/output_drain_fifo.sv
// Result drain FIFO with run-tracking controller.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   ST_IDLE   | no run in progress; results are still accepted
//   ST_ACTIVE | controller busy, results streaming in
//   ST_FLUSH  | controller finished, waiting for the host to empty us
//   ST_DONE   | run fully drained; done is high for this one cycle
module output_drain_fifo
  import output_drain_fifo_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int DATA_WIDTH  = ODF_DATA_WIDTH,
  parameter int COORD_WIDTH = ODF_COORD_WIDTH
) (
  input  logic                   clk,
  input  logic                   arst_n_in,
  input  logic                   running,
  output_drain_fifo_if.slave     bus,
  output logic                   almost_full,
  output logic                   overflow,
  output logic                   done,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = entry_width(DATA_WIDTH, COORD_WIDTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] ALMOST_C = CW'(DEPTH - 2);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  // Same field order as odf_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [DATA_WIDTH-1:0]  data;
    logic [COORD_WIDTH-1:0] x;
    logic [COORD_WIDTH-1:0] y;
    logic [COORD_WIDTH-1:0] ch;
  } entry_t;

  entry_t      wr_entry;
  entry_t      rd_entry;
  logic        push;
  logic        pop;
  logic        drop;
  odf_state_e  state;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop  = bus.out_valid & bus.out_ready;
  assign push = bus.in_valid & ((count != DEPTH_C) | pop);
  assign drop = bus.in_valid & ~push;

  assign wr_entry = '{data: bus.in_data, x: bus.in_x, y: bus.in_y, ch: bus.in_ch};

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .wr_en     (push),
    .wr_data   (wr_entry),
    .rd_en     (pop),
    .rd_data   (rd_entry),
    .count     (count)
  );

  // Status flags are pure decodes of the registered count.
  assign bus.out_valid = (count != '0);
  assign almost_full   = (count >= ALMOST_C);

  assign bus.out_data = rd_entry.data;
  assign bus.out_x    = rd_entry.x;
  assign bus.out_y    = rd_entry.y;
  assign bus.out_ch   = rd_entry.ch;

  // Run sequencing, done pulse and sticky overflow.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state    <= ST_IDLE;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      if (drop) overflow <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (running) begin
            state <= ST_ACTIVE;
            // A drop in the very cycle the new run starts still counts.
            if (!drop) overflow <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (!running) state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (running) begin
            state <= ST_ACTIVE;
          end else if ((count == '0) || ((count == ONE_C) && pop)) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_drain_fifo.sv
// Randomized and directed bench for output_drain_fifo against a queue-based model.
module tb_output_drain_fifo;
  import output_drain_fifo_pkg::*;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       arst_n_in = 1'b0;
  logic       running = 1'b0;
  logic       almost_full;
  logic       overflow;
  logic       done;
  logic [3:0] count;

  output_drain_fifo_if #(.DATA_WIDTH(32), .COORD_WIDTH(32)) bus ();

  output_drain_fifo #(
    .DEPTH       (DEPTH),
    .DATA_WIDTH  (32),
    .COORD_WIDTH (32)
  ) dut (
    .clk         (clk),
    .arst_n_in   (arst_n_in),
    .running     (running),
    .bus         (bus),
    .almost_full (almost_full),
    .overflow    (overflow),
    .done        (done),
    .count       (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] ch;
  } ent_t;

  // Reference model: a plain queue plus a run phase and a sticky drop flag.
  localparam int M_IDLE   = 0;
  localparam int M_ACTIVE = 1;
  localparam int M_FLUSH  = 2;
  localparam int M_DONE   = 3;

  ent_t q[$];
  int   m_mode = M_IDLE;
  bit   m_ovf  = 1'b0;

  int n_checks  = 0;
  int n_errors  = 0;
  int done_seen = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    if (done === 1'b1) done_seen++;
    chk_eq("count", 64'(count), 64'(q.size()));
    chk_eq("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
    chk_eq("almost_full", 64'(almost_full), 64'(q.size() >= DEPTH - 2));
    chk_eq("overflow", 64'(overflow), 64'(m_ovf));
    chk_eq("done", 64'(done), 64'(m_mode == M_DONE));
    if (q.size() != 0) begin
      chk_eq("out_data", 64'(bus.out_data), 64'(q[0].d));
      chk_eq("out_x", 64'(bus.out_x), 64'(q[0].x));
      chk_eq("out_y", 64'(bus.out_y), 64'(q[0].y));
      chk_eq("out_ch", 64'(bus.out_ch), 64'(q[0].ch));
    end
  endtask

  // Called at a falling edge: check, drive one cycle of inputs, advance the model.
  task automatic cycle(input bit run, input bit iv, input logic [31:0] d,
                       input logic [31:0] x, input bit rdy);
    ent_t e;
    int   sz;
    bit   pop, push, drop;
    check_outputs();
    e.d  = d;
    e.x  = x;
    e.y  = $urandom;
    e.ch = $urandom;
    running       = run;
    bus.in_valid  = iv;
    bus.in_data   = e.d;
    bus.in_x      = e.x;
    bus.in_y      = e.y;
    bus.in_ch     = e.ch;
    bus.out_ready = rdy;

    sz   = q.size();
    pop  = (sz > 0) && rdy;
    push = iv && ((sz < DEPTH) || pop);
    drop = iv && !push;

    case (m_mode)
      M_IDLE:   if (run) begin m_mode = M_ACTIVE; m_ovf = 1'b0; end
      M_ACTIVE: if (!run) m_mode = M_FLUSH;
      M_FLUSH: begin
        if (run) m_mode = M_ACTIVE;
        else if (sz - int'(pop) == 0) m_mode = M_DONE;
      end
      default:  m_mode = M_IDLE;
    endcase
    if (drop) m_ovf = 1'b1;
    if (pop) void'(q.pop_front());
    if (push) q.push_back(e);

    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a falling edge: asynchronous reset pulse, checked while held.
  task automatic do_reset();
    arst_n_in     = 1'b0;
    running       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    chk_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk_eq("rst_count", 64'(count), 64'd0);
    chk_eq("rst_overflow", 64'(overflow), 64'd0);
    chk_eq("rst_done", 64'(done), 64'd0);
    chk_eq("rst_almost_full", 64'(almost_full), 64'd0);
    q.delete();
    m_mode = M_IDLE;
    m_ovf  = 1'b0;
    @(negedge clk);
    arst_n_in = 1'b1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.in_ch     = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);

    // Basic in-order delivery.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, 1, 32'(i + 1), 32'(i), 1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 1);

    // Fill, overflow on the 9th push, then drain.
    do_reset();
    for (int i = 0; i < 9; i++) cycle(1, 1, 32'(i + 10), 32'(i), 0);
    for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0, 1);

    // Push and pop together at full.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1, 1, 32'(i + 20), 32'(i), 0);
    cycle(1, 1, 32'h100, 32'h100, 1);
    chk_eq("simul_full_count", 64'(count), 64'd8);
    chk_eq("simul_full_ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < 9; i++) cycle(1, 0, 0, 0, 1);

    // Flush with a slow host: exactly one done pulse.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 1, 32'(i + 40), 32'(i), 0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) cycle(0, 0, 0, 0, (i % 2) == 0);
    chk_eq("flush_done_pulses", 64'(done_seen), 64'd1);

    // Running returns while flushing: back to ACTIVE, no done.
    do_reset();
    for (int i = 0; i < 2; i++) cycle(1, 1, 32'(i + 50), 32'(i), 0);
    done_seen = 0;
    cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 0);
    chk_eq("rerun_done_pulses", 64'(done_seen), 64'd0);
    chk_eq("rerun_state", 64'(dut.state), 64'(ST_ACTIVE));

    // Reset in the middle of a run.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 1, 32'(i + 60), 32'(i), 0);
    chk_eq("midrun_count", 64'(count), 64'd5);
    done_seen = 0;
    do_reset();
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1);
    chk_eq("midrun_done_pulses", 64'(done_seen), 64'd0);

    // Random traffic with varying host pressure and run toggling.
    do_reset();
    begin
      bit run_r = 1'b1;
      int rdy_pct = 50;
      for (int c = 0; c < 3000; c++) begin
        if ((c % 200) == 0) rdy_pct = $urandom_range(0, 100);
        if ($urandom_range(0, 39) == 0) run_r = ~run_r;
        cycle(run_r, $urandom_range(0, 99) < 60, $urandom, $urandom,
              $urandom_range(0, 99) < rdy_pct);
      end
    end
    for (int i = 0; i < 12; i++) cycle(0, 0, 0, 0, 1);
    check_outputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/output_drain_fifo.md
OUTPUT_DRAIN_FIFO -- requirements
Module: output_drain_fifo

Interface
REQ-001 The block SHALL expose parameter DEPTH, default 8, meaning the number of result entries stored, a power of two no smaller than 4.
REQ-002 The block SHALL expose parameter DATA_WIDTH, default 32, meaning the width of one output result word.
REQ-003 The block SHALL expose parameter COORD_WIDTH, default 32, meaning the width of each of the x, y and ch tags.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port arst_n_in, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port running, input, 1 bit: the controller's busy flag.
REQ-007 Port in_valid, input, 1 bit: one result is presented this cycle; there is no backpressure on this port.
REQ-008 Port in_data, input, DATA_WIDTH bits: the result word.
REQ-009 Ports in_x, in_y and in_ch, input, COORD_WIDTH bits each: the result coordinates.
REQ-010 Port out_valid, output, 1 bit: the head entry is available to the host.
REQ-011 Port out_ready, input, 1 bit: the host accepts the head entry.
REQ-012 Ports out_data (DATA_WIDTH), out_x, out_y and out_ch (COORD_WIDTH each), outputs: the head entry.
REQ-013 Port almost_full, output, 1 bit: asserted when count >= DEPTH-2; the controller holds before issuing a new CC sequence.
REQ-014 Port overflow, output, 1 bit: sticky flag meaning a result was dropped.
REQ-015 Port done, output, 1 bit: one-cycle pulse when a run has fully drained.
REQ-016 Port count, output, $clog2(DEPTH)+1 bits: the current occupancy.

Function
REQ-017 A push SHALL occur when in_valid=1 and (count<DEPTH or a pop occurs in the same cycle).
REQ-018 A pop SHALL occur when out_valid=1 and out_ready=1.
REQ-019 out_valid SHALL equal (count!=0); head data SHALL be stable while out_valid=1 and out_ready=0.
REQ-020 Latency from a push to out_valid SHALL be 1 cycle; there is no combinational bypass from in_* to out_*.
REQ-021 A push and a pop in the same cycle SHALL leave count unchanged, including at count=0 (no pop is possible) and count=DEPTH (both are accepted).
REQ-022 When in_valid=1, count=DEPTH and there is no pop, the entry SHALL be dropped, overflow SHALL be set, and count and the pointers SHALL be unchanged.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-024 out_ready while out_valid=0 SHALL have no effect.
REQ-025 The FSM SHALL have states IDLE, ACTIVE, FLUSH and DONE.
REQ-026 IDLE->ACTIVE on running=1.
REQ-027 ACTIVE->FLUSH on running=0.
REQ-028 FLUSH->DONE when count=0, or when count=1 and a pop occurs.
REQ-029 DONE->IDLE unconditionally; done=1 only in DONE.
REQ-030 In IDLE, pushes SHALL still be accepted so that no data is lost.
REQ-031 If running rises again in FLUSH, the FSM SHALL go to ACTIVE without pulsing done.
REQ-032 overflow SHALL be cleared only by reset or by the IDLE->ACTIVE transition.

Reset
REQ-033 On arst_n_in=0 the block SHALL asynchronously force:
- pointers=0, count=0;
- FSM=IDLE;
- out_valid=0, almost_full=0, overflow=0, done=0.
REQ-034 Reset SHALL discard stored contents; out_data, out_x, out_y and out_ch are don't-care while out_valid=0.
REQ-035 Reset asserted mid-run SHALL produce no done pulse.

Structure
REQ-036 The shared package SHALL hold the state enum and the entry struct {data, x, y, ch}.
REQ-037 Storage and pointers SHALL live in one sub-module, sync_fifo, parameterised by DEPTH and entry width; the FSM and flags SHALL live in the top level.
REQ-038 All registers SHALL use the codebase register macro/module with the asynchronous active-low reset.

Verification
REQ-039 Basic: DEPTH=8, running=1, 3 pushes (data 1..3, x=0..2), out_ready=1 -> out_data 1,2,3 in order, each 1 cycle after its push, count back to 0.
REQ-040 Full: 8 pushes with out_ready=0, then a 9th push -> count=8, almost_full=1 from count=6, overflow=1, the 9th entry absent from the later drain.
REQ-041 Simultaneous at full: count=8, in_valid=1 and out_ready=1 in the same cycle -> count stays 8, overflow=0, the new entry is emitted last.
REQ-042 Flush: 4 entries queued, running falls, host drains 1 per 2 cycles -> done pulses exactly once, the cycle after the 4th pop.
REQ-043 Re-run in FLUSH: running falls with count=2 and rises 1 cycle later -> no done pulse, state ACTIVE.
REQ-044 Reset mid-run: count=5, arst_n_in pulsed low -> out_valid=0, count=0, overflow=0, no done pulse.
